// File: rtl/xor_nn_if.sv
// Input/output bundle for the xor_nn fixed-weight XOR network.
// Carries out_valid only when XOR_NN_VALID_EN is defined.
interface xor_nn_if;
    logic [1:0]  x;
    logic [16:0] out;
`ifdef XOR_NN_VALID_EN
    logic        out_valid;

    modport master (output x, input out, input out_valid);
    modport slave  (input x, output out, output out_valid);
`else
    modport master (output x, input out);
    modport slave  (input x, output out);
`endif
endinterface

// File: rtl/xor_nn.sv
// 2-2-1 hard-sigmoid network computing XOR, five-stage pipeline.
// Define XOR_NN_VALID_EN to expose out_valid on the interface.
module xor_nn #(
    parameter logic signed [23:0] W1 = 24'sh080000,
    parameter logic signed [23:0] B1 = -24'sh040000,
    parameter logic signed [23:0] B2 = -24'sh0C0000,
    parameter logic signed [23:0] W2 = 24'sh080000,
    parameter logic signed [23:0] B3 = -24'sh040000
) (
    input  logic     clock,
    input  logic     reset_n,
    xor_nn_if.slave  nn
);

    // clamp(z/4 + 0.5, 0, 1) in Q1.16
    function automatic logic [16:0] hs(input logic signed [25:0] z);
        logic signed [26:0] t;
        t = ($signed({z[25], z}) >>> 2) + 27'sd32768;
        if (t < 27'sd0)
            hs = 17'h00000;
        else if (t > 27'sd65536)
            hs = 17'h10000;
        else
            hs = t[16:0];
    endfunction

    logic [1:0]         r_x;
    logic signed [25:0] r_z1;
    logic signed [25:0] r_z2;
    logic [16:0]        r_h1;
    logic [16:0]        r_h2;
    logic signed [25:0] r_z3;
    logic [16:0]        r_out;
    logic [4:0]         r_v;

    logic signed [25:0] w_w1;
    logic signed [25:0] w_b1;
    logic signed [25:0] w_b2;
    logic signed [25:0] w_b3;
    logic signed [25:0] w_sum;
    logic signed [41:0] w_w2;
    logic signed [41:0] w_h1x;
    logic signed [41:0] w_h2x;
    logic signed [41:0] w_p1;
    logic signed [41:0] w_p2;
    logic signed [41:0] w_diff;
    logic signed [25:0] w_z3;

    assign w_w1 = {{2{W1[23]}}, W1};
    assign w_b1 = {{2{B1[23]}}, B1};
    assign w_b2 = {{2{B2[23]}}, B2};
    assign w_b3 = {{2{B3[23]}}, B3};

    // input bits act as selects on the shared hidden weight
    assign w_sum = (r_x[0] ? w_w1 : 26'sd0)
                 + (r_x[1] ? w_w1 : 26'sd0);

    assign w_w2   = {{18{W2[23]}}, W2};
    assign w_h1x  = {25'd0, r_h1};
    assign w_h2x  = {25'd0, r_h2};
    assign w_p1   = w_h1x * w_w2;
    assign w_p2   = w_h2x * w_w2;
    assign w_diff = w_p1 - w_p2;
    // dropping the low 16 bits floors toward minus infinity
    assign w_z3   = $signed(w_diff[41:16]) + w_b3;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_x   <= '0;
            r_z1  <= '0;
            r_z2  <= '0;
            r_h1  <= '0;
            r_h2  <= '0;
            r_z3  <= '0;
            r_out <= '0;
            r_v   <= '0;
        end else begin
            r_v  <= {r_v[3:0], 1'b1};
            r_x  <= nn.x;
            r_z1 <= w_sum + w_b1;
            r_z2 <= w_sum + w_b2;
            r_h1 <= hs(r_z1);
            r_h2 <= hs(r_z2);
            r_z3 <= w_z3;
            // zeroed stages would otherwise leak a 0.5 after reset
            if (r_v[3])
                r_out <= hs(r_z3);
            else
                r_out <= 17'h00000;
        end
    end

    assign nn.out = r_out;

    logic w_unused;
`ifdef XOR_NN_VALID_EN
    assign nn.out_valid = r_v[4];
    assign w_unused     = ^w_diff[15:0];
`else
    assign w_unused     = ^{w_diff[15:0], r_v[4]};
`endif

endmodule

// File: tb/tb_xor_nn.sv
// Randomised self-checking bench for xor_nn against an arithmetic model.
// Checks default weights and a W2=4.0 override side by side.
module tb_xor_nn;

    logic clk;
    logic rst_n;
    int   vec;
    int   miss;
    int   run;
    logic [1:0] hist[$];

    xor_nn_if ifa ();
    xor_nn_if ifb ();

    xor_nn u_a (
        .clock   (clk),
        .reset_n (rst_n),
        .nn      (ifa)
    );

    xor_nn #(
        .W2 (24'sh040000)
    ) u_b (
        .clock   (clk),
        .reset_n (rst_n),
        .nn      (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0)))
            q = q - 1;
        return q;
    endfunction

    function automatic longint ref_hs(input longint z);
        longint t;
        t = fdiv(z, 4) + 32768;
        if (t < 0)
            return 0;
        if (t > 65536)
            return 65536;
        return t;
    endfunction

    // values in units of 2^-16
    function automatic logic [16:0] ref_out(input logic [1:0] xv, input longint w2);
        longint s;
        longint h1;
        longint h2;
        longint z3;
        s  = (longint'(xv[0]) + longint'(xv[1])) * 524288;
        h1 = ref_hs(s - 262144);
        h2 = ref_hs(s - 786432);
        z3 = fdiv((h1 - h2) * w2, 65536) - 262144;
        return 17'(ref_hs(z3));
    endfunction

    task automatic step(input logic [1:0] xv, input logic rn,
                        output logic [16:0] ea, output logic [16:0] eb,
                        output logic ev);
        @(negedge clk);
        ifa.x = xv;
        ifb.x = xv;
        rst_n = rn;
        @(posedge clk);
        #1;
        hist.push_back(xv);
        if (!rn)
            run = 0;
        else
            run = run + 1;
        if (run >= 5) begin
            ea = ref_out(hist[$-4], 524288);
            eb = ref_out(hist[$-4], 262144);
            ev = 1'b1;
        end else begin
            ea = 17'h0;
            eb = 17'h0;
            ev = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [16:0] ea, eb;
        logic ev;
        for (int i = 0; i < 9; i++) begin
            step(2'b11, (i >= 3), ea, eb, ev);
            vec++;
            if (ifa.out !== ea) begin
                miss++;
                $display("FAIL reset out_a cyc %0d got %h exp %h", i, ifa.out, ea);
            end
            vec++;
            if (ifb.out !== eb) begin
                miss++;
                $display("FAIL reset out_b cyc %0d got %h exp %h", i, ifb.out, eb);
            end
`ifdef XOR_NN_VALID_EN
            vec++;
            if (ifa.out_valid !== ev) begin
                miss++;
                $display("FAIL reset valid cyc %0d got %b exp %b", i, ifa.out_valid, ev);
            end
`endif
        end
    endtask

    task automatic test_truth_table();
        logic [16:0] ea, eb;
        logic ev;
        logic [1:0] seq[12] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10,
                                2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 12; i++) begin
            step(seq[i], 1'b1, ea, eb, ev);
            vec++;
            if (ifa.out !== ea) begin
                miss++;
                $display("FAIL truth out_a cyc %0d got %h exp %h", i, ifa.out, ea);
            end
            vec++;
            if (ifb.out !== eb) begin
                miss++;
                $display("FAIL truth out_b cyc %0d got %h exp %h", i, ifb.out, eb);
            end
        end
    endtask

    task automatic test_throughput();
        logic [16:0] ea, eb;
        logic ev;
        for (int i = 0; i < 24; i++) begin
            step((i % 2 == 0) ? 2'b01 : 2'b11, 1'b1, ea, eb, ev);
            vec++;
            if (ifa.out !== ea) begin
                miss++;
                $display("FAIL thru out_a cyc %0d got %h exp %h", i, ifa.out, ea);
            end
            vec++;
            if (ifb.out !== eb) begin
                miss++;
                $display("FAIL thru out_b cyc %0d got %h exp %h", i, ifb.out, eb);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] ea, eb;
        logic ev;
        for (int i = 0; i < 14; i++) begin
            step(2'b01, (i != 6), ea, eb, ev);
            vec++;
            if (ifa.out !== ea) begin
                miss++;
                $display("FAIL midrst out_a cyc %0d got %h exp %h", i, ifa.out, ea);
            end
            vec++;
            if (ifb.out !== eb) begin
                miss++;
                $display("FAIL midrst out_b cyc %0d got %h exp %h", i, ifb.out, eb);
            end
`ifdef XOR_NN_VALID_EN
            vec++;
            if (ifa.out_valid !== ev) begin
                miss++;
                $display("FAIL midrst valid cyc %0d got %b exp %b", i, ifa.out_valid, ev);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [16:0] ea, eb;
        logic ev;
        logic [1:0] xv;
        logic rn;
        for (int i = 0; i < 80; i++) begin
            xv = 2'($urandom_range(3));
            rn = ($urandom_range(19) != 0);
            step(xv, rn, ea, eb, ev);
            vec++;
            if (ifa.out !== ea) begin
                miss++;
                $display("FAIL rand out_a cyc %0d got %h exp %h", i, ifa.out, ea);
            end
            vec++;
            if (ifb.out !== eb) begin
                miss++;
                $display("FAIL rand out_b cyc %0d got %h exp %h", i, ifb.out, eb);
            end
`ifdef XOR_NN_VALID_EN
            vec++;
            if (ifa.out_valid !== ev) begin
                miss++;
                $display("FAIL rand valid cyc %0d got %b exp %b", i, ifa.out_valid, ev);
            end
`endif
        end
    endtask

    initial begin
        vec   = 0;
        miss  = 0;
        run   = 0;
        rst_n = 1'b0;
        ifa.x = 2'b00;
        ifb.x = 2'b00;
        test_reset();
        test_truth_table();
        test_throughput();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
